seven_seg_scanner: RTL and testbench
====================================

# seven_seg_scanner

Display-side reader for the stopwatch's 16-bit BCD count (MM:SS, digit 4 = tens of minutes … digit 1 = units of seconds). Registers a tear-free snapshot of Q once per scan frame and time-multiplexes the four digits onto a common-anode 7-segment display. Provides:
- anti-ghosting blanking between digits;
- error glyphs for invalid BCD;
- a minutes/seconds separator dot;
- whole-display blink for the paused state.

Sits between the stopwatch counter output and the board pins.

## Interface
- REFRESH_DIV, 50000, clk_in cycles per digit slot (≥ 2)
- BLANK_CYC, 500, cycles at the start of each slot with all anodes off (1 ≤ BLANK_CYC < REFRESH_DIV)
- BLINK_DIV, 12500000, cycles per blink half-period (≥ 2)

Ports:
- clk_in  in  1  single clock; all state on rising edge
- RESET  in  1  asynchronous, active-low reset
- Q  in  16  BCD count from the stopwatch: [4:1] sec units, [8:5] sec tens, [12:9] min units, [16:13] min tens
- BLINK  in  1  1 = blank the display during odd blink phases
- AN  out  4  digit anodes, active-low; AN[k] drives digit k
- SEG  out  7  segments {g,f,e,d,c,b,a}, active-low
- DP  out  1  decimal point, active-low

## Operation
- State machine per slot: BLANK (BLANK_CYC cycles) → DRIVE (REFRESH_DIV − BLANK_CYC cycles) → BLANK of next digit.
- Digit index order: 1 → 2 → 3 → 4 → 1.
- Snapshot register (16 bits) loads Q on the cycle entering BLANK of digit 1. Q changes mid-frame are not displayed until the next frame.
- In DRIVE, only AN[idx] = 0. SEG = decode(snapshot nibble idx).
- In BLANK: AN = 4'b1111. SEG and DP also forced inactive (all 1).
- Decode values:
  - 0 = 1000000
  - 1 = 1111001
  - 2 = 0100100
  - 3 = 0110000
  - 4 = 0011001
  - 5 = 0010010
  - 6 = 0000010
  - 7 = 1111000
  - 8 = 0000000
  - 9 = 0010000
  - nibble ≥ 10 = "E" 0000110
- DP = 0 only while digit 3 is in DRIVE (separator). Otherwise DP = 1.
- Blink:
  - Free-running counter 0..BLINK_DIV−1 toggles phase at wrap. Phase is 0 after reset.
  - While BLINK=1 and phase=1, AN forced to 1111. Scan, snapshot and counters keep running.
  - BLINK is sampled every cycle, with no hold-over.
- No leading-zero suppression; all four digits are always shown.

## Timing
- Reset values, asserted asynchronously while RESET=0:
  - outputs: AN=1111, SEG=1111111, DP=1
  - internal: state=BLANK, idx=1, slot counter=0, blink counter=0, phase=0, snapshot=0
- After RESET rises: the first edge begins BLANK of digit 1 and loads the snapshot from Q.
- AN, SEG and DP are registered: each reflects the state/counters of the previous cycle (1-cycle latency).
- First driven digit: AN=1110 appears BLANK_CYC+1 edges after reset release.
- One frame = 4·REFRESH_DIV cycles. The snapshot is reloaded exactly once per frame.
- Never more than one AN bit low in any cycle.
- Segment data changes only while AN=1111.
- BLINK change takes effect on AN one cycle later.
- RESET asserted mid-slot: outputs go inactive immediately (asynchronously). Scanning restarts at digit 1 with a fresh snapshot.

## Structure
- Package seven_seg_pkg holds:
  - the segment glyph constants (digits 0–9, GLYPH_E, GLYPH_OFF)
  - the state enum {S_BLANK, S_DRIVE}
  - digit-index constants
- Sub-module bcd_to_seg7: combinational 4-bit → 7-bit decoder implementing the table above, instantiated once on the selected snapshot nibble.
- Top contains the slot/blink counters, FSM, snapshot register and output registers.

## Test plan
Bench parameters: REFRESH_DIV=8, BLANK_CYC=2, BLINK_DIV=64.
- Reset hold with Q=16'h1234: AN=1111, SEG=1111111, DP=1 throughout; after release, AN=1110 with SEG=0011001 ("4") at edge 3, lasting 6 cycles.
- Q=16'h4059 static: over one 32-cycle frame, digits show 9, 5, 0, 4. DP=0 only during AN=1011. AN=1111 for 2 cycles before each digit.
- Q changes from 16'h1020 to 16'h1021 mid-frame during digit 2: digit 1 keeps showing "0" until the next frame, then shows "1".
- Q=16'h00A0 (invalid tens): digit 2 shows 0000110. Other digits show "0".
- BLINK=1, Q=16'h0000:
  - AN=1111 for the 64-cycle odd phases; normal scanning in even phases.
  - Deasserting BLINK mid-odd-phase restores scanning one cycle later.
- RESET pulsed low during DRIVE of digit 3: outputs inactive in the same cycle. After release, scanning restarts at digit 1 with a new snapshot.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the 4-digit multiplexed 7-segment scanner.
package seven_seg_pkg;

   // Segment glyphs, bit order {g,f,e,d,c,b,a}, active-low.
   localparam logic [6:0] GLYPH_0   = 7'b1000000;
   localparam logic [6:0] GLYPH_1   = 7'b1111001;
   localparam logic [6:0] GLYPH_2   = 7'b0100100;
   localparam logic [6:0] GLYPH_3   = 7'b0110000;
   localparam logic [6:0] GLYPH_4   = 7'b0011001;
   localparam logic [6:0] GLYPH_5   = 7'b0010010;
   localparam logic [6:0] GLYPH_6   = 7'b0000010;
   localparam logic [6:0] GLYPH_7   = 7'b1111000;
   localparam logic [6:0] GLYPH_8   = 7'b0000000;
   localparam logic [6:0] GLYPH_9   = 7'b0010000;
   localparam logic [6:0] GLYPH_E   = 7'b0000110;
   localparam logic [6:0] GLYPH_OFF = 7'b1111111;

   // All anodes released (display dark).
   localparam logic [3:0] AN_OFF = 4'b1111;

   // Digit indices: digit 1 (seconds units) sits in the lowest nibble and drives AN[0].
   localparam logic [1:0] DIG_1 = 2'd0;
   localparam logic [1:0] DIG_2 = 2'd1;
   localparam logic [1:0] DIG_3 = 2'd2;
   localparam logic [1:0] DIG_4 = 2'd3;

   // Per-slot phase: anti-ghosting gap first, then the digit is lit.
   typedef enum logic {
      S_BLANK = 1'b0,
      S_DRIVE = 1'b1
   } state_t;

endpackage

// File: rtl/seven_seg_scanner_bcd_to_seg7.sv
// Combinational BCD nibble to active-low 7-segment glyph; non-BCD values show "E".
module bcd_to_seg7
   import seven_seg_pkg::*;
(
   input  logic [3:0] i_nibble,
   output logic [6:0] o_seg
);

   // Glyph lookup; anything above 9 is flagged with the error glyph.
   always_comb begin
      o_seg = GLYPH_E;
      case (i_nibble)
         4'd0:    o_seg = GLYPH_0;
         4'd1:    o_seg = GLYPH_1;
         4'd2:    o_seg = GLYPH_2;
         4'd3:    o_seg = GLYPH_3;
         4'd4:    o_seg = GLYPH_4;
         4'd5:    o_seg = GLYPH_5;
         4'd6:    o_seg = GLYPH_6;
         4'd7:    o_seg = GLYPH_7;
         4'd8:    o_seg = GLYPH_8;
         4'd9:    o_seg = GLYPH_9;
         default: o_seg = GLYPH_E;
      endcase
   end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed MM:SS display driver: frame snapshot, blank/drive slots, blink, registered pins.
module seven_seg_scanner
   import seven_seg_pkg::*;
#(
   parameter int REFRESH_DIV = 50000,
   parameter int BLANK_CYC   = 500,
   parameter int BLINK_DIV   = 12500000
) (
   input  logic        clk_in,
   input  logic        RESET,
   input  logic [15:0] Q,
   input  logic        BLINK,
   output logic [3:0]  AN,
   output logic [6:0]  SEG,
   output logic        DP
);

   localparam int SLOT_W  = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam int BLINK_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

   localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(REFRESH_DIV - 1);
   localparam logic [SLOT_W-1:0]  BLANK_LAST = SLOT_W'(BLANK_CYC - 1);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

   state_t               r_state;
   state_t               w_state_next;
   logic [SLOT_W-1:0]    r_slot_cnt;
   logic [SLOT_W-1:0]    w_slot_next;
   logic [1:0]           r_idx;
   logic [1:0]           w_idx_next;
   logic [BLINK_W-1:0]   r_blink_cnt;
   logic                 r_phase;
   logic [15:0]          r_snapshot;
   logic                 w_snap_load;

   logic [3:0]           w_nibble;
   logic [6:0]           w_seg_dec;
   logic [3:0]           w_an_drive;
   logic                 w_blanked;

   logic [3:0]           w_an_next;
   logic [6:0]           w_seg_next;
   logic                 w_dp_next;
   logic [3:0]           r_an;
   logic [6:0]           r_seg;
   logic                 r_dp;

   // The snapshot is captured in the very first cycle of digit 1's blank gap, once per frame.
   assign w_snap_load = (r_state == S_BLANK) && (r_idx == DIG_1) && (r_slot_cnt == '0);

   // Display is suppressed only in the odd blink half-period while BLINK is requested.
   assign w_blanked = BLINK & r_phase;

   // Nibble for the digit currently being scanned.
   assign w_nibble = r_snapshot[{r_idx, 2'b00} +: 4];

   bcd_to_seg7 u_dec (
      .i_nibble (w_nibble),
      .o_seg    (w_seg_dec)
   );

   // One-hot-low anode pattern: only the selected digit's anode is pulled low.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_an
         assign w_an_drive[gi] = ~(r_idx == 2'(gi));
      end
   endgenerate

   // Slot FSM next state: blank gap, then drive until the slot ends, then next digit.
   always_comb begin
      w_state_next = r_state;
      w_slot_next  = r_slot_cnt + SLOT_W'(1);
      w_idx_next   = r_idx;
      if (r_slot_cnt == SLOT_LAST) begin
         w_slot_next = '0;
         w_idx_next  = r_idx + 2'd1;
      end
      case (r_state)
         S_BLANK: if (r_slot_cnt == BLANK_LAST) w_state_next = S_DRIVE;
         S_DRIVE: if (r_slot_cnt == SLOT_LAST)  w_state_next = S_BLANK;
         default: w_state_next = S_BLANK;
      endcase
   end

   // Slot FSM state, slot counter and digit index.
   always_ff @(posedge clk_in or negedge RESET) begin
      if (!RESET) begin
         r_state    <= S_BLANK;
         r_slot_cnt <= '0;
         r_idx      <= DIG_1;
      end else begin
         r_state    <= w_state_next;
         r_slot_cnt <= w_slot_next;
         r_idx      <= w_idx_next;
      end
   end

   // Tear-free frame snapshot of the stopwatch count.
   always_ff @(posedge clk_in or negedge RESET) begin
      if (!RESET) begin
         r_snapshot <= '0;
      end else if (w_snap_load) begin
         r_snapshot <= Q;
      end
   end

   // Free-running blink timer; phase flips each time the counter wraps.
   always_ff @(posedge clk_in or negedge RESET) begin
      if (!RESET) begin
         r_blink_cnt <= '0;
         r_phase     <= 1'b0;
      end else if (r_blink_cnt == BLINK_LAST) begin
         r_blink_cnt <= '0;
         r_phase     <= ~r_phase;
      end else begin
         r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
      end
   end

   // Pin values for the next cycle: everything dark in the gap, glyph and separator in drive.
   always_comb begin
      w_an_next  = AN_OFF;
      w_seg_next = GLYPH_OFF;
      w_dp_next  = 1'b1;
      if (r_state == S_DRIVE) begin
         w_an_next  = w_blanked ? AN_OFF : w_an_drive;
         w_seg_next = w_seg_dec;
         w_dp_next  = (r_idx != DIG_3);
      end
   end

   // Registered pins so the board sees glitch-free, single-cycle-latency outputs.
   always_ff @(posedge clk_in or negedge RESET) begin
      if (!RESET) begin
         r_an  <= AN_OFF;
         r_seg <= GLYPH_OFF;
         r_dp  <= 1'b1;
      end else begin
         r_an  <= w_an_next;
         r_seg <= w_seg_next;
         r_dp  <= w_dp_next;
      end
   end

   assign AN  = r_an;
   assign SEG = r_seg;
   assign DP  = r_dp;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner: model predicts pins per edge, monitor compares.
module tb_seven_seg_scanner;

   localparam int RD    = 8;
   localparam int BC    = 2;
   localparam int BD    = 64;
   localparam int FRAME = 4 * RD;

   logic        clk_in = 1'b0;
   logic        RESET  = 1'b0;
   logic [15:0] Q      = 16'h0000;
   logic        BLINK  = 1'b0;
   logic [3:0]  AN;
   logic [6:0]  SEG;
   logic        DP;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
   } exp_t;

   localparam exp_t EXP_IDLE = '{an: 4'b1111, seg: 7'b1111111, dp: 1'b1};

   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;

   // Reference model state: cycles since reset release, and the frame's captured count.
   int          k_model  = 0;
   logic [15:0] snap_m   = 16'h0000;

   logic [6:0] glyph_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                   7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                   7'b0000000, 7'b0010000};

   seven_seg_scanner #(
      .REFRESH_DIV (RD),
      .BLANK_CYC   (BC),
      .BLINK_DIV   (BD)
   ) dut (
      .clk_in (clk_in),
      .RESET  (RESET),
      .Q      (Q),
      .BLINK  (BLINK),
      .AN     (AN),
      .SEG    (SEG),
      .DP     (DP)
   );

   always #5 clk_in = ~clk_in;

   // Expected pins for the edge that leaves cycle kk (kk cycles after reset release).
   function automatic exp_t model_out(int kk, logic [15:0] snap, logic blink);
      exp_t       e;
      int         slot;
      int         digit;
      int         phase;
      logic [3:0] nib;
      logic [3:0] one;
      slot  = kk % RD;
      digit = (kk / RD) % 4;
      phase = (kk / BD) % 2;
      e     = EXP_IDLE;
      if (slot >= BC) begin
         nib   = snap[4*digit +: 4];
         one   = 4'b0001 << digit;
         e.seg = (nib < 4'd10) ? glyph_tab[nib] : 7'b0000110;
         e.an  = (blink && phase == 1) ? 4'b1111 : ~one;
         e.dp  = (digit == 2) ? 1'b0 : 1'b1;
      end
      return e;
   endfunction

   // Drive one cycle of inputs and queue what the pins must show after the next edge.
   task automatic step(input logic rst, input logic [15:0] q, input logic blink);
      exp_t e;
      if (!rst && RESET) exp_q.push_back(EXP_IDLE);
      RESET = rst;
      Q     = q;
      BLINK = blink;
      if (!rst) begin
         e       = EXP_IDLE;
         k_model = 0;
      end else begin
         e = model_out(k_model, snap_m, blink);
         if (k_model % FRAME == 0) snap_m = q;
         k_model++;
      end
      exp_q.push_back(e);
      @(negedge clk_in);
   endtask

   task automatic run(input int n, input logic [15:0] q, input logic blink);
      for (int i = 0; i < n; i++) step(1'b1, q, blink);
   endtask

   task automatic hold_reset(input int n);
      for (int i = 0; i < n; i++) step(1'b0, Q, BLINK);
   endtask

   // Monitor: every clock edge (and every asynchronous reset assertion) retires one expectation.
   initial begin
      exp_t e;
      #2;
      forever begin
         @(posedge clk_in or negedge RESET);
         #1;
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_underflow t=%0t AN=%b SEG=%b DP=%b required=queued entry",
                     $time, AN, SEG, DP);
         end else begin
            e = exp_q.pop_front();
            if ({AN, SEG, DP} !== e) begin
               n_fail++;
               $display("FAIL pins t=%0t AN=%b SEG=%b DP=%b required AN=%b SEG=%b DP=%b",
                        $time, AN, SEG, DP, e.an, e.seg, e.dp);
            end
         end
      end
   end

   // Stimulus: directed scenarios, then randomized traffic.
   initial begin
      logic [15:0] rq;
      logic        rb;
      logic        rr;

      $display("scenario reset_hold Q=1234");
      for (int i = 0; i < 4; i++) step(1'b0, 16'h1234, 1'b0);
      run(40, 16'h1234, 1'b0);

      $display("scenario static Q=4059");
      hold_reset(2);
      run(40, 16'h4059, 1'b0);

      $display("scenario midframe_change 1020->1021");
      hold_reset(2);
      run(12, 16'h1020, 1'b0);
      run(60, 16'h1021, 1'b0);

      $display("scenario invalid_bcd Q=00A0");
      hold_reset(2);
      run(40, 16'h00A0, 1'b0);

      $display("scenario blink Q=0000");
      hold_reset(2);
      run(80, 16'h0000, 1'b1);
      run(20, 16'h0000, 1'b0);
      run(100, 16'h0000, 1'b1);

      $display("scenario reset_during_digit3 Q=5678");
      hold_reset(2);
      run(21, 16'h5678, 1'b0);
      hold_reset(2);
      run(40, 16'h9876, 1'b0);

      $display("scenario random traffic");
      rq = 16'h0000;
      rb = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(15, 0) == 0) begin
            if ($urandom_range(1, 0) == 0)
               rq = {4'($urandom_range(9, 0)), 4'($urandom_range(9, 0)),
                     4'($urandom_range(9, 0)), 4'($urandom_range(9, 0))};
            else
               rq = 16'($urandom);
         end
         if ($urandom_range(19, 0) == 0) rb = ~rb;
         rr = ($urandom_range(299, 0) != 0);
         step(rr, rq, rb);
      end

      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain left=%0d required=0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
